// File: rtl/ram_dump_uart_stream_if.sv
// RAM read port plus byte-transmitter handshake between the dumper and its neighbours.
// master: the dumper (drives reads and launches bytes); slave: RAM + UART byte engine.
interface ram_dump_uart_stream_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 32
);
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic [7:0]        tx_data;
  logic              tx_start;
  logic              tx_done;

  modport master (
    output rd_en, rd_addr, tx_data, tx_start,
    input  rd_data, tx_done
  );

  modport slave (
    input  rd_en, rd_addr, tx_data, tx_start,
    output rd_data, tx_done
  );
endinterface

// File: rtl/ram_dump_uart_stream.sv
// Streams RAM words start..end (inclusive, wrapping) to a UART byte transmitter, with an
// optional header byte, selectable byte order and an optional 8-bit checksum trailer.
module ram_dump_uart_stream #(
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned RD_LAT    = 1,
  parameter bit          MSB_FIRST = 1'b0,
  parameter bit          HDR_EN    = 1'b1,
  parameter logic [7:0]  HDR_BYTE  = 8'hA5,
  parameter bit          CSUM_EN   = 1'b1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [ADDR_W-1:0]     start_addr_i,
  input  logic [ADDR_W-1:0]     end_addr_i,
  input  logic                  abort_i,
  output logic                  busy_o,
  output logic                  done_o,
  ram_dump_uart_stream_if.master bus_io
);

  localparam int unsigned NBYTES = DATA_W / 8;
  localparam int unsigned IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  typedef enum logic [3:0] {
    StIdle,
    StHdr,
    StHdrWait,
    StRd,
    StRdWait,
    StByte,
    StByteWait,
    StNext,
    StCsum,
    StCsumWait,
    StFin
  } state_e;

  state_e            state_q;
  logic              rd_en_q;
  logic              tx_start_q;
  logic              busy_q;
  logic              done_q;
  logic [ADDR_W-1:0] rd_addr_q;
  logic [ADDR_W-1:0] end_addr_q;
  logic [DATA_W-1:0] word_q;
  logic [7:0]        tx_data_q;
  logic [7:0]        csum_q;
  logic [IDX_W-1:0]  idx_q;
  logic [2:0]        lat_q;
  logic [7:0]        cur_byte;

  assign bus_io.rd_en    = rd_en_q;
  assign bus_io.rd_addr  = rd_addr_q;
  assign bus_io.tx_data  = tx_data_q;
  assign bus_io.tx_start = tx_start_q;
  assign busy_o          = busy_q;
  assign done_o          = done_q;

  // Select the byte of the captured word addressed by the byte index and the byte order.
  always_comb begin
    int unsigned idx;
    int unsigned sh;
    idx      = 32'(idx_q);
    sh       = MSB_FIRST ? (DATA_W - 8 - 8 * idx) : (8 * idx);
    cur_byte = 8'(word_q >> sh);
  end

  // Dump sequencer; every output is a register written only here.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      rd_en_q    <= 1'b0;
      tx_start_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rd_addr_q  <= '0;
      end_addr_q <= '0;
      word_q     <= '0;
      tx_data_q  <= '0;
      csum_q     <= '0;
      idx_q      <= '0;
      lat_q      <= '0;
    end else if (abort_i && (state_q != StIdle)) begin
      // A byte already launched is left to the transmitter; nothing new is issued.
      state_q    <= StIdle;
      rd_en_q    <= 1'b0;
      tx_start_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      rd_en_q    <= 1'b0;
      tx_start_q <= 1'b0;
      done_q     <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            rd_addr_q  <= start_addr_i;
            end_addr_q <= end_addr_i;
            csum_q     <= '0;
            busy_q     <= 1'b1;
            state_q    <= HDR_EN ? StHdr : StRd;
          end
        end
        StHdr: begin
          tx_data_q  <= HDR_BYTE;
          tx_start_q <= 1'b1;
          state_q    <= StHdrWait;
        end
        StHdrWait: begin
          if (bus_io.tx_done) state_q <= StRd;
        end
        StRd: begin
          rd_en_q <= 1'b1;
          lat_q   <= '0;
          state_q <= StRdWait;
        end
        StRdWait: begin
          // lat_q reaches RD_LAT on the edge where rd_data is valid.
          if (lat_q == 3'(RD_LAT)) begin
            word_q  <= bus_io.rd_data;
            idx_q   <= '0;
            state_q <= StByte;
          end else begin
            lat_q <= lat_q + 3'd1;
          end
        end
        StByte: begin
          tx_data_q  <= cur_byte;
          tx_start_q <= 1'b1;
          csum_q     <= csum_q + cur_byte;
          state_q    <= StByteWait;
        end
        StByteWait: begin
          if (bus_io.tx_done) begin
            if (idx_q == IDX_W'(NBYTES - 1)) begin
              state_q <= StNext;
            end else begin
              idx_q   <= idx_q + 1'b1;
              state_q <= StByte;
            end
          end
        end
        StNext: begin
          if (rd_addr_q == end_addr_q) begin
            state_q <= CSUM_EN ? StCsum : StFin;
          end else begin
            rd_addr_q <= rd_addr_q + 1'b1;
            state_q   <= StRd;
          end
        end
        StCsum: begin
          tx_data_q  <= csum_q;
          tx_start_q <= 1'b1;
          state_q    <= StCsumWait;
        end
        StCsumWait: begin
          if (bus_io.tx_done) state_q <= StFin;
        end
        StFin: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
